// File: rtl/ifu_fetch_stage.sv
// rtl/ifu_fetch_stage.sv - instruction fetch stage: PC, next-PC select and IF/ID register
// Branch/jump targets are formed from the IF/ID PC because control resolves in ID.
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          IM_DEPTH  = 4096,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [11:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] pc_f,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        id_exc
);

    localparam logic [31:0] PC_LAST = RESET_PC + 32'(IM_DEPTH) * 32'd4 - 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc8;
    logic        r_id_valid;
    logic        r_id_exc;

    logic [31:0] w_id_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_fetch_err;

    assign w_id_pc4    = r_id_pc + 32'd4;
    assign w_br_off    = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign w_fetch_err = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc > PC_LAST);

    always_comb begin
        w_npc = r_pc + 32'd4;
        case (npc_sel)
            2'b00:   w_npc = r_pc + 32'd4;
            2'b01:   w_npc = w_id_pc4 + w_br_off;
            2'b10:   w_npc = {w_id_pc4[31:28], j_index, 2'b00};
            default: w_npc = jr_target;
        endcase
    end

    // Flush beats stall; a stalled cycle ignores npc_sel since ID re-presents it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_id_instr <= '0;
            r_id_pc    <= '0;
            r_id_pc8   <= '0;
            r_id_valid <= 1'b0;
            r_id_exc   <= 1'b0;
        end else if (flush) begin
            r_pc       <= EXC_ENTRY;
            r_id_instr <= '0;
            r_id_pc    <= EXC_ENTRY;
            r_id_pc8   <= EXC_ENTRY + 32'd8;
            r_id_valid <= 1'b0;
            r_id_exc   <= 1'b0;
        end else if (!stall) begin
            r_pc       <= w_npc;
            r_id_instr <= w_fetch_err ? 32'd0 : im_instr;
            r_id_pc    <= r_pc;
            r_id_pc8   <= r_pc + 32'd8;
            r_id_valid <= 1'b1;
            r_id_exc   <= w_fetch_err;
        end
    end

    assign im_addr  = r_pc[13:2];
    assign pc_f     = r_pc;
    assign id_instr = r_id_instr;
    assign id_pc    = r_id_pc;
    assign id_pc8   = r_id_pc8;
    assign id_valid = r_id_valid;
    assign id_exc   = r_id_exc;

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// tb/tb_ifu_fetch_stage.sv - directed and randomized checks of ifu_fetch_stage
module tb_ifu_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          IM_DEPTH  = 4096;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [15:0] br_imm = '0;
    logic [25:0] j_index = '0;
    logic [31:0] jr_target = '0;
    logic [11:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_f;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
    logic        id_exc;

    logic [31:0] mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc8;
    logic        m_valid, m_exc;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    ifu_fetch_stage #(
        .RESET_PC (RESET_PC),
        .IM_DEPTH (IM_DEPTH),
        .EXC_ENTRY(EXC_ENTRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .npc_sel  (npc_sel),
        .br_imm   (br_imm),
        .j_index  (j_index),
        .jr_target(jr_target),
        .im_addr  (im_addr),
        .im_instr (im_instr),
        .pc_f     (pc_f),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_pc8   (id_pc8),
        .id_valid (id_valid),
        .id_exc   (id_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] pc);
        longint unsigned last;
        last = longint'(RESET_PC) + 4 * IM_DEPTH - 4;
        return (pc % 4 != 0) || (longint'(pc) < longint'(RESET_PC)) || (longint'(pc) > last);
    endfunction

    function automatic logic [31:0] im_word(input logic [31:0] pc);
        return mem[(pc / 4) % 4096];
    endfunction

    task automatic step(input bit rst, input bit st, input bit fl, input logic [1:0] sel,
                        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
        logic [31:0] tgt;
        int          off;
        reset = rst; stall = st; flush = fl;
        npc_sel = sel; br_imm = imm; j_index = idx; jr_target = jr;
        if (rst) begin
            m_pc = RESET_PC; m_instr = 0; m_idpc = 0; m_idpc8 = 0; m_valid = 0; m_exc = 0;
        end else if (fl) begin
            m_pc = EXC_ENTRY; m_instr = 0; m_idpc = EXC_ENTRY; m_idpc8 = EXC_ENTRY + 8;
            m_valid = 0; m_exc = 0;
        end else if (!st) begin
            off = $signed(imm);
            case (sel)
                2'd0: tgt = m_pc + 4;
                2'd1: tgt = m_idpc + 4 + 32'(off * 4);
                2'd2: tgt = ((m_idpc + 4) & 32'hF000_0000) | (32'(idx) * 4);
                default: tgt = jr;
            endcase
            m_exc   = bad_addr(m_pc);
            m_instr = m_exc ? 32'd0 : im_word(m_pc);
            m_idpc  = m_pc;
            m_idpc8 = m_pc + 8;
            m_valid = 1;
            m_pc    = tgt;
        end
        @(posedge clk);
        #1;
        check("pc_f", pc_f, m_pc);
        check("im_addr", 32'(im_addr), (m_pc / 4) % 4096);
        check("id_instr", id_instr, m_instr);
        check("id_pc", id_pc, m_idpc);
        check("id_pc8", id_pc8, m_idpc8);
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("id_exc", 32'(id_exc), 32'(m_exc));
    endtask

    task automatic seq_step();
        step(0, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] snap_pc, snap_idpc, snap_instr;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        // 1: reset and sequential fetch
        step(1, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
        step(1, 1, 1, 2'b01, 16'h0, 26'h0, 32'h0);
        check("reset_pc", pc_f, 32'h3000);
        check("reset_valid", 32'(id_valid), 32'd0);
        seq_step();
        check("seq_pc1", pc_f, 32'h3004);
        check("seq_pc8", id_pc8, 32'h3008);
        check("seq_instr0", id_instr, mem[12'hC00]);
        seq_step();
        check("seq_pc2", pc_f, 32'h3008);
        check("seq_instr1", id_instr, mem[12'hC01]);
        seq_step(); seq_step(); seq_step();
        check("at_3014", id_pc, 32'h3010);

        // 2: branches from id_pc = 0x3010
        step(0, 0, 0, 2'b01, 16'hFFFC, 26'h0, 32'h0);
        check("br_back", pc_f, 32'h3004);
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h3010);
        seq_step();
        step(0, 0, 0, 2'b01, 16'h0003, 26'h0, 32'h0);
        check("br_fwd", pc_f, 32'h3020);

        // 3: jump and jump-register
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h3010);
        seq_step();
        step(0, 0, 0, 2'b10, 16'h0, 26'h0000C40, 32'h0);
        check("jump", pc_f, 32'h3100);
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h3200);
        check("jr", pc_f, 32'h3200);

        // 4: three-cycle stall holding a branch
        snap_pc = pc_f; snap_idpc = id_pc; snap_instr = id_instr;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 2'b01, 16'h0010, 26'h0, 32'h0);
            check("stall_pc", pc_f, snap_pc);
            check("stall_idpc", id_pc, snap_idpc);
            check("stall_instr", id_instr, snap_instr);
        end
        step(0, 0, 0, 2'b01, 16'h0010, 26'h0, 32'h0);
        check("stall_release", pc_f, snap_idpc + 32'd4 + 32'h40);

        // 5: flush with stall
        step(0, 1, 1, 2'b00, 16'h0, 26'h0, 32'h0);
        check("flush_pc", pc_f, 32'h4180);
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_instr", id_instr, 32'd0);
        seq_step();
        check("post_flush_idpc", id_pc, 32'h4180);
        check("post_flush_valid", 32'(id_valid), 32'd1);

        // 6: misaligned and out-of-range jr
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h3002);
        seq_step();
        check("mis_exc", 32'(id_exc), 32'd1);
        check("mis_idpc", id_pc, 32'h3002);
        check("mis_instr", id_instr, 32'd0);
        check("mis_next", pc_f, 32'h3006);
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h7000);
        seq_step();
        check("oor_exc", 32'(id_exc), 32'd1);
        check("oor_idpc", id_pc, 32'h7000);
        check("oor_instr", id_instr, 32'd0);
        check("oor_next", pc_f, 32'h7004);
        step(0, 0, 0, 2'b11, 16'h0, 26'h0, 32'h6FFC);
        seq_step();
        check("last_ok", 32'(id_exc), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] jr;
            bit rst, st, fl;
            rst = ($urandom_range(0, 99) < 2);
            fl  = ($urandom_range(0, 99) < 5);
            st  = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 9) < 8) jr = RESET_PC + 4 * $urandom_range(0, 4095);
            else                          jr = $urandom;
            step(rst, st, fl, 2'($urandom), 16'($urandom), 26'($urandom), jr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
